cfa_window_ctrl: RTL and testbench

CFA_WINDOW_CTRL -- requirements
Module: cfa_window_ctrl

---
 rtl/cfa_window_ctrl.sv | 128 ++++++++++++
 tb/tb_cfa_window_ctrl.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cfa_window_ctrl.sv
// cfa_window_ctrl: frame sequencer for a 3x3 Bayer demosaic window. It walks
// the raster, gates line-buffer shifts, and tags each complete window with its centre and CFA colour.
`default_nettype none

module cfa_window_ctrl #(
  parameter int         IMG_W = 640,
  parameter int         IMG_H = 480,
  parameter logic [1:0] BAYER = 2'b00
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        buf_en,
  output logic        buf_clr,
  input  logic        out_ready,
  output logic        out_valid,
  output logic [15:0] ctr_row,
  output logic [15:0] ctr_col,
  output logic [1:0]  bayer_phase,
  output logic        rb_interp,
  output logic        busy,
  output logic        frame_done
);

  localparam logic [15:0] LAST_COL = 16'(IMG_W - 1);
  localparam logic [15:0] LAST_ROW = 16'(IMG_H - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t      state;
  logic [15:0] row;
  logic [15:0] col;

  logic        accept;
  logic        win_pix;
  logic        last_pix;
  logic [15:0] cen_row;
  logic [15:0] cen_col;
  logic [1:0]  cen_phase;

  // A held window blocks the buffer: shifting would overwrite its pixels.
  assign in_ready  = (state == RUN) & (~out_valid | out_ready);
  assign accept    = in_valid & in_ready;
  assign buf_en    = accept;

  assign win_pix   = (row >= 16'd2) && (col >= 16'd2);
  assign last_pix  = (row == LAST_ROW) && (col == LAST_COL);
  assign cen_row   = row - 16'd1;
  assign cen_col   = col - 16'd1;
  assign cen_phase = {cen_row[0], cen_col[0]} ^ BAYER;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      row         <= 16'd0;
      col         <= 16'd0;
      ctr_row     <= 16'd0;
      ctr_col     <= 16'd0;
      bayer_phase <= 2'd0;
      rb_interp   <= 1'b0;
      out_valid   <= 1'b0;
      buf_clr     <= 1'b0;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
    end else begin
      buf_clr    <= 1'b0;
      frame_done <= 1'b0;

      case (state)
        IDLE: begin
          if (start) begin
            state   <= CLEAR;
            buf_clr <= 1'b1;
            busy    <= 1'b1;
          end
        end
        CLEAR: begin
          state <= RUN;
          row   <= 16'd0;
          col   <= 16'd0;
        end
        RUN: begin
          if (accept) begin
            if (col == LAST_COL) begin
              col <= 16'd0;
              row <= row + 16'd1;
            end else begin
              col <= col + 16'd1;
            end
            if (last_pix) begin
              state      <= DONE;
              busy       <= 1'b0;
              frame_done <= 1'b1;
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase

      // The buffer has one cycle of latency, so the window centred one row
      // and one column behind the accepted pixel is complete next cycle.
      if (accept && win_pix) begin
        out_valid   <= 1'b1;
        ctr_row     <= cen_row;
        ctr_col     <= cen_col;
        bayer_phase <= cen_phase;
        rb_interp   <= (cen_phase == 2'd0) || (cen_phase == 2'd3);
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_cfa_window_ctrl.sv
// tb_cfa_window_ctrl: directed frames on a 4x4 image checked against a
// pixel-count model every cycle, plus literal checks of the window sequence.
`default_nettype none

module tb_cfa_window_ctrl;

  localparam int W = 4;
  localparam int H = 4;
  localparam int B = 0;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        in_valid;
  logic        in_ready;
  logic        buf_en;
  logic        buf_clr;
  logic        out_ready;
  logic        out_valid;
  logic [15:0] ctr_row;
  logic [15:0] ctr_col;
  logic [1:0]  bayer_phase;
  logic        rb_interp;
  logic        busy;
  logic        frame_done;

  cfa_window_ctrl #(.IMG_W(W), .IMG_H(H), .BAYER(2'(B))) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid),
    .in_ready(in_ready), .buf_en(buf_en), .buf_clr(buf_clr),
    .out_ready(out_ready), .out_valid(out_valid), .ctr_row(ctr_row),
    .ctr_col(ctr_col), .bayer_phase(bayer_phase), .rb_interp(rb_interp),
    .busy(busy), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: phase 0 idle, 1 clear, 2 run, 3 done; pixels tracked by raster index.
  int m_st = 0, m_n = 0, m_r = 0, m_c = 0, m_widx = 0;
  bit m_ov = 1'b0;

  always @(posedge clk) begin
    bit acc;
    int pr, pc;
    acc = (m_st == 2) && in_valid && (!m_ov || out_ready);
    if (rst) begin
      m_st = 0; m_n = 0; m_ov = 0; m_r = 0; m_c = 0; m_widx = 0;
    end else begin
      if (m_ov && out_ready) m_widx++;
      if (acc) begin
        pr = m_n / W;
        pc = m_n % W;
        m_n++;
        if (pr >= 2 && pc >= 2) begin
          m_ov = 1; m_r = pr - 1; m_c = pc - 1;
        end else if (out_ready) m_ov = 0;
      end else if (out_ready) m_ov = 0;
      case (m_st)
        0: if (start) m_st = 1;
        1: begin m_st = 2; m_n = 0; m_widx = 0; end
        2: if (acc && m_n == W * H) m_st = 3;
        default: m_st = 0;
      endcase
    end
  end

  bit chk_on = 1'b0;
  int cnt_be = 0, cnt_clr = 0, cnt_fd = 0;
  int nrise = 0, nh = 0;
  int rise_be [64];
  int hs_r [64], hs_c [64], hs_ph [64], hs_rb [64];
  bit prev_ov = 1'b0;

  always @(negedge clk) begin
    int ph;
    if (chk_on) begin
      chk("in_ready", int'(in_ready), int'((m_st == 2) && (!m_ov || out_ready)));
      chk("buf_en", int'(buf_en), int'((m_st == 2) && (!m_ov || out_ready) && in_valid));
      chk("buf_clr", int'(buf_clr), int'(m_st == 1));
      chk("busy", int'(busy), int'(m_st == 1 || m_st == 2));
      chk("frame_done", int'(frame_done), int'(m_st == 3));
      chk("out_valid", int'(out_valid), int'(m_ov));
      if (m_ov) begin
        ph = ((m_r % 2) * 2 + (m_c % 2)) ^ B;
        chk("ctr_row", int'(ctr_row), m_r);
        chk("ctr_col", int'(ctr_col), m_c);
        chk("bayer_phase", int'(bayer_phase), ph);
        chk("rb_interp", int'(rb_interp), int'(ph == 0 || ph == 3));
        if (out_ready) begin
          chk("sb_row", int'(ctr_row), m_widx / (W - 2) + 1);
          chk("sb_col", int'(ctr_col), m_widx % (W - 2) + 1);
        end
      end
    end
    if (out_valid === 1'b1 && !prev_ov && nrise < 64) begin
      rise_be[nrise] = cnt_be;
      nrise++;
    end
    prev_ov = (out_valid === 1'b1);
    if (out_valid === 1'b1 && out_ready && nh < 64) begin
      hs_r[nh] = int'(ctr_row); hs_c[nh] = int'(ctr_col);
      hs_ph[nh] = int'(bayer_phase); hs_rb[nh] = int'(rb_interp);
      nh++;
    end
    if (buf_en === 1'b1) cnt_be++;
    if (buf_clr === 1'b1) cnt_clr++;
    if (frame_done === 1'b1) cnt_fd++;
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_fd(input int base, input bit toggle);
    int k = 0;
    while (cnt_fd == base && k < 200) begin
      if (toggle) in_valid = ~in_valid;
      cyc();
      k++;
    end
    chk("frame_done_seen", int'(cnt_fd != base), 1);
  endtask

  task automatic chk_win(input int i, input int r, input int c);
    chk("win_row", hs_r[i], r);
    chk("win_col", hs_c[i], c);
  endtask

  task automatic chk_frame(input int be0, input int nh0);
    chk("accepts_per_frame", cnt_be - be0, 16);
    chk("windows_per_frame", nh - nh0, 4);
    chk_win(nh0, 1, 1);
    chk_win(nh0 + 1, 1, 2);
    chk_win(nh0 + 2, 2, 1);
    chk_win(nh0 + 3, 2, 2);
  endtask

  initial begin
    int be0, clr0, fd0, nr0, nh0, k;
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    cyc();
    chk_on = 1'b1;
    cyc();
    rst = 1'b0;
    cyc();
    chk("rst_ctr_row", int'(ctr_row), 0);
    chk("rst_ctr_col", int'(ctr_col), 0);
    chk("rst_phase", int'(bayer_phase), 0);
    chk("rst_busy", int'(busy), 0);

    // Continuous streaming frame
    be0 = cnt_be; clr0 = cnt_clr; fd0 = cnt_fd; nr0 = nrise; nh0 = nh;
    start = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    cyc();
    start = 1'b0;
    wait_fd(fd0, 1'b0);
    repeat (3) cyc();
    chk_frame(be0, nh0);
    chk("clr_cycles", cnt_clr - clr0, 1);
    chk("done_cycles", cnt_fd - fd0, 1);
    chk("first_ov_after_accepts", rise_be[nr0] - be0, 11);
    chk("win0_phase", hs_ph[nh0], 3);
    chk("win0_rb", hs_rb[nh0], 1);
    chk("win1_phase", hs_ph[nh0 + 1], 2);
    chk("win1_rb", hs_rb[nh0 + 1], 0);

    // Back-pressure for 5 cycles, then a stray start during RUN
    be0 = cnt_be; clr0 = cnt_clr; fd0 = cnt_fd; nh0 = nh;
    start = 1'b1;
    cyc();
    start = 1'b0;
    k = 0;
    while (out_valid !== 1'b1 && k < 50) begin cyc(); k++; end
    chk("stall_ov_seen", int'(out_valid === 1'b1), 1);
    out_ready = 1'b0;
    repeat (5) cyc();
    chk("stall_in_ready", int'(in_ready), 0);
    chk("stall_buf_en", int'(buf_en), 0);
    out_ready = 1'b1;
    cyc();
    start = 1'b1;
    cyc();
    start = 1'b0;
    wait_fd(fd0, 1'b0);
    repeat (3) cyc();
    chk_frame(be0, nh0);
    chk("stray_start_clr", cnt_clr - clr0, 1);

    // in_valid alternating each cycle
    be0 = cnt_be; fd0 = cnt_fd; nh0 = nh;
    start = 1'b1; in_valid = 1'b0;
    cyc();
    start = 1'b0;
    wait_fd(fd0, 1'b1);
    in_valid = 1'b1;
    repeat (3) cyc();
    chk_frame(be0, nh0);

    // Reset held 2 cycles mid-RUN aborts the frame
    fd0 = cnt_fd;
    start = 1'b1;
    cyc();
    start = 1'b0;
    repeat (6) cyc();
    rst = 1'b1;
    repeat (2) cyc();
    chk("abort_busy", int'(busy), 0);
    chk("abort_out_valid", int'(out_valid), 0);
    chk("abort_in_ready", int'(in_ready), 0);
    rst = 1'b0;
    be0 = cnt_be;
    repeat (5) cyc();
    chk("abort_no_done", cnt_fd - fd0, 0);
    chk("abort_needs_start", cnt_be - be0, 0);

    // Fresh frame after the abort
    be0 = cnt_be; fd0 = cnt_fd; nh0 = nh;
    start = 1'b1;
    cyc();
    start = 1'b0;
    wait_fd(fd0, 1'b0);
    repeat (3) cyc();
    chk_frame(be0, nh0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
